// File: rtl/ssd1306_spi_sink.sv
// ssd1306_spi_sink: display-side receiver for the SSD1306 4-wire SPI link.
// Ports: clk_in/resetn_in; oled_csn/dc/clk/mosi_in pins;
// byte_stb/byte/byte_dc out; fb_we/fb_addr/fb_data out; display_on/frame_stb out.
module ssd1306_spi_sink #(
  parameter int COLS = 128,
  parameter int PAGES = 8,
  localparam int COL_W = $clog2(COLS),
  localparam int PAGE_W = $clog2(PAGES),
  localparam int ADDR_W = PAGE_W + COL_W
) (
  input  logic              clk_in,
  input  logic              resetn_in,
  input  logic              oled_csn_in,
  input  logic              oled_dc_in,
  input  logic              oled_clk_in,
  input  logic              oled_mosi_in,
  output logic              byte_stb_out,
  output logic [7:0]        byte_out,
  output logic              byte_dc_out,
  output logic              fb_we_out,
  output logic [ADDR_W-1:0] fb_addr_out,
  output logic [7:0]        fb_data_out,
  output logic              display_on_out,
  output logic              frame_stb_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_COL_S, S_COL_E, S_PG_S, S_PG_E, S_MODE, S_SKIP1
  } state_t;

  typedef enum logic [1:0] {
    M_HORZ = 2'b00, M_VERT = 2'b01, M_PAGE = 2'b10
  } mode_t;

  logic [1:0] csn_s, dc_s, sclk_s, mosi_s;
  logic sclk_p;
  logic edge_q, csn_q, dc_q, mosi_q;
  logic [2:0] cnt;
  logic [6:0] sr;

  logic rx_done;
  logic [7:0] rx_byte;

  state_t state, state_n;
  mode_t mode, mode_n;
  logic [COL_W-1:0] col, col_n, col_s, cs_n, col_e, ce_n, col_inc;
  logic [PAGE_W-1:0] page, page_n, pg_s, ps_n, pg_e, pe_n, page_inc;
  logic [7:0] col8;
  logic disp_n, we_n, frame_n;
  logic [ADDR_W-1:0] addr_cur;

  function automatic logic [COL_W-1:0] mod_col(input logic [7:0] b);
    return COL_W'(32'(b) % COLS);
  endfunction

  function automatic logic [PAGE_W-1:0] mod_pg(input logic [7:0] b);
    return PAGE_W'(32'(b) % PAGES);
  endfunction

  // Pins cross in through two flops; an extra stage aligns data with
  // the registered edge so the byte strobe lands 4 clocks after the pin edge.
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      csn_s  <= 2'b11;
      dc_s   <= '0;
      sclk_s <= '0;
      mosi_s <= '0;
      sclk_p <= 1'b0;
      edge_q <= 1'b0;
      csn_q  <= 1'b1;
      dc_q   <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      csn_s  <= {csn_s[0], oled_csn_in};
      dc_s   <= {dc_s[0], oled_dc_in};
      sclk_s <= {sclk_s[0], oled_clk_in};
      mosi_s <= {mosi_s[0], oled_mosi_in};
      sclk_p <= sclk_s[1];
      edge_q <= sclk_s[1] & ~sclk_p;
      csn_q  <= csn_s[1];
      dc_q   <= dc_s[1];
      mosi_q <= mosi_s[1];
    end
  end

  assign rx_done = edge_q & ~csn_q & (cnt == 3'd7);
  assign rx_byte = {sr, mosi_q};

  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      cnt <= '0;
      sr  <= '0;
    end else if (csn_q) begin
      cnt <= '0;
    end else if (edge_q) begin
      sr  <= rx_byte[6:0];
      cnt <= cnt + 3'd1;
    end
  end

  assign col8 = 8'(col);
  assign addr_cur = ADDR_W'(page) * ADDR_W'(COLS) + ADDR_W'(col);
  assign col_inc = (col == COL_W'(COLS - 1)) ? '0 : col + 1'b1;
  assign page_inc = (page == PAGE_W'(PAGES - 1)) ? '0 : page + 1'b1;

  always_comb begin
    state_n = state;
    mode_n  = mode;
    col_n   = col;
    page_n  = page;
    cs_n    = col_s;
    ce_n    = col_e;
    ps_n    = pg_s;
    pe_n    = pg_e;
    disp_n  = display_on_out;
    we_n    = 1'b0;
    frame_n = 1'b0;
    if (rx_done && dc_q) begin
      // Data aborts any pending parameter and is written at the pointer.
      state_n = S_IDLE;
      we_n    = 1'b1;
      unique case (mode)
        M_HORZ: begin
          if (col == col_e) begin
            col_n   = col_s;
            page_n  = (page == pg_e) ? pg_s : page_inc;
            frame_n = (page == pg_e);
          end else begin
            col_n = col_inc;
          end
        end
        M_VERT: begin
          if (page == pg_e) begin
            page_n  = pg_s;
            col_n   = (col == col_e) ? col_s : col_inc;
            frame_n = (col == col_e);
          end else begin
            page_n = page_inc;
          end
        end
        default: col_n = col_inc;
      endcase
    end else if (rx_done) begin
      unique case (state)
        S_IDLE: begin
          if (rx_byte == 8'h21) state_n = S_COL_S;
          else if (rx_byte == 8'h22) state_n = S_PG_S;
          else if (rx_byte == 8'h20) state_n = S_MODE;
          else if (rx_byte == 8'hAE) disp_n = 1'b0;
          else if (rx_byte == 8'hAF) disp_n = 1'b1;
          else if (rx_byte[7:4] == 4'h0)
            col_n = COL_W'({col8[7:4], rx_byte[3:0]});
          else if (rx_byte[7:4] == 4'h1)
            col_n = COL_W'({rx_byte[3:0], col8[3:0]});
          else if (rx_byte[7:3] == 5'b10110)
            page_n = mod_pg({5'd0, rx_byte[2:0]});
          else if (rx_byte inside {8'h81, 8'h8D, 8'hA8, 8'hD3,
                                   8'hD5, 8'hD9, 8'hDA, 8'hDB})
            state_n = S_SKIP1;
        end
        S_COL_S: begin
          cs_n    = mod_col(rx_byte);
          state_n = S_COL_E;
        end
        S_COL_E: begin
          ce_n    = mod_col(rx_byte);
          col_n   = col_s;
          state_n = S_IDLE;
        end
        S_PG_S: begin
          ps_n    = mod_pg(rx_byte);
          state_n = S_PG_E;
        end
        S_PG_E: begin
          pe_n    = mod_pg(rx_byte);
          page_n  = pg_s;
          state_n = S_IDLE;
        end
        S_MODE: begin
          if (rx_byte[1:0] != 2'b11) mode_n = mode_t'(rx_byte[1:0]);
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) state <= S_IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      mode           <= M_PAGE;
      col            <= '0;
      page           <= '0;
      col_s          <= '0;
      col_e          <= COL_W'(COLS - 1);
      pg_s           <= '0;
      pg_e           <= PAGE_W'(PAGES - 1);
      byte_stb_out   <= 1'b0;
      byte_out       <= '0;
      byte_dc_out    <= 1'b0;
      fb_we_out      <= 1'b0;
      fb_addr_out    <= '0;
      fb_data_out    <= '0;
      display_on_out <= 1'b0;
      frame_stb_out  <= 1'b0;
    end else begin
      mode           <= mode_n;
      col            <= col_n;
      page           <= page_n;
      col_s          <= cs_n;
      col_e          <= ce_n;
      pg_s           <= ps_n;
      pg_e           <= pe_n;
      byte_stb_out   <= rx_done;
      fb_we_out      <= we_n;
      frame_stb_out  <= frame_n;
      display_on_out <= disp_n;
      if (rx_done) begin
        byte_out    <= rx_byte;
        byte_dc_out <= dc_q;
      end
      if (we_n) begin
        fb_addr_out <= addr_cur;
        fb_data_out <= rx_byte;
      end
    end
  end

endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// tb_ssd1306_spi_sink: directed bench for ssd1306_spi_sink.
// Drives SPI bytes on the pins and checks strobes captured by a monitor.
module tb_ssd1306_spi_sink;

  logic clk_in = 1'b0;
  logic resetn_in, oled_csn_in, oled_dc_in, oled_clk_in, oled_mosi_in;
  logic byte_stb_out, byte_dc_out, fb_we_out, display_on_out, frame_stb_out;
  logic [7:0] byte_out, fb_data_out;
  logic [9:0] fb_addr_out;

  int vectors = 0;
  int errors = 0;
  int stray_frame = 0;
  logic [18:0] wr_q[$];
  logic [8:0] by_q[$];

  ssd1306_spi_sink dut (
    .clk_in(clk_in),
    .resetn_in(resetn_in),
    .oled_csn_in(oled_csn_in),
    .oled_dc_in(oled_dc_in),
    .oled_clk_in(oled_clk_in),
    .oled_mosi_in(oled_mosi_in),
    .byte_stb_out(byte_stb_out),
    .byte_out(byte_out),
    .byte_dc_out(byte_dc_out),
    .fb_we_out(fb_we_out),
    .fb_addr_out(fb_addr_out),
    .fb_data_out(fb_data_out),
    .display_on_out(display_on_out),
    .frame_stb_out(frame_stb_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (fb_we_out) wr_q.push_back({frame_stb_out, fb_addr_out, fb_data_out});
    else if (frame_stb_out) stray_frame++;
    if (byte_stb_out) by_q.push_back({byte_dc_out, byte_out});
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_wr(input string tag, input int idx,
                           input logic fr, input logic [9:0] a,
                           input logic [7:0] d);
    logic [18:0] e;
    e = (idx < wr_q.size()) ? wr_q[idx] : 'x;
    check(tag, 32'(e), 32'({fr, a, d}));
  endtask

  task automatic clear_q();
    wr_q.delete();
    by_q.delete();
  endtask

  task automatic spi_bit(input logic b, input logic d);
    @(posedge clk_in); #1;
    oled_clk_in = 1'b0;
    oled_mosi_in = b;
    oled_dc_in = d;
    repeat (2) @(posedge clk_in);
    #1 oled_clk_in = 1'b1;
    @(posedge clk_in);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    for (int k = 7; k >= 0; k--) spi_bit(b[k], d);
  endtask

  task automatic cs_start();
    @(posedge clk_in); #1 oled_csn_in = 1'b0;
    repeat (2) @(posedge clk_in);
  endtask

  task automatic cs_end();
    @(posedge clk_in); #1 oled_clk_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 oled_csn_in = 1'b1;
    repeat (6) @(posedge clk_in);
  endtask

  task automatic settle();
    repeat (8) @(posedge clk_in);
    #1;
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_bstb"}, 32'(byte_stb_out), 0);
    check({tag, "_byte"}, 32'(byte_out), 0);
    check({tag, "_bdc"}, 32'(byte_dc_out), 0);
    check({tag, "_we"}, 32'(fb_we_out), 0);
    check({tag, "_addr"}, 32'(fb_addr_out), 0);
    check({tag, "_data"}, 32'(fb_data_out), 0);
    check({tag, "_disp"}, 32'(display_on_out), 0);
    check({tag, "_frame"}, 32'(frame_stb_out), 0);
  endtask

  initial begin
    logic [7:0] af;
    resetn_in = 1'b0;
    oled_csn_in = 1'b1;
    oled_dc_in = 1'b0;
    oled_clk_in = 1'b0;
    oled_mosi_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check_outs_zero("rst");
    resetn_in = 1'b1;
    repeat (3) @(posedge clk_in);

    // 0xAF with exact strobe latency after the 8th rising edge
    clear_q();
    cs_start();
    af = 8'hAF;
    for (int k = 7; k >= 1; k--) spi_bit(af[k], 1'b0);
    @(posedge clk_in); #1;
    oled_clk_in = 1'b0;
    oled_mosi_in = af[0];
    repeat (2) @(posedge clk_in);
    #1 oled_clk_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 check("af_stb_early", 32'(byte_stb_out), 0);
    @(posedge clk_in);
    #1;
    check("af_stb", 32'(byte_stb_out), 1);
    check("af_byte", 32'(byte_out), 32'h AF);
    check("af_dc", 32'(byte_dc_out), 0);
    check("af_disp", 32'(display_on_out), 1);
    @(posedge clk_in);
    #1 check("af_stb_pulse", 32'(byte_stb_out), 0);
    settle();
    check("af_nbytes", by_q.size(), 1);
    check("af_nwr", wr_q.size(), 0);

    // horizontal, full window, 1024 + 1 data bytes
    send_byte(8'h20, 0); send_byte(8'h00, 0);
    send_byte(8'h21, 0); send_byte(8'h00, 0); send_byte(8'h7F, 0);
    send_byte(8'h22, 0); send_byte(8'h00, 0); send_byte(8'h07, 0);
    settle();
    clear_q();
    for (int i = 0; i <= 1024; i++) send_byte(8'(i), 1'b1);
    settle();
    check("h_nwr", wr_q.size(), 1025);
    for (int i = 0; i <= 1024; i++)
      expect_wr($sformatf("h_wr%0d", i), i, (i == 1023),
                10'(i % 1024), 8'(i));

    // page mode addressing and column wrap
    send_byte(8'h20, 0); send_byte(8'h02, 0);
    send_byte(8'hB3, 0); send_byte(8'h05, 0); send_byte(8'h12, 0);
    settle();
    clear_q();
    send_byte(8'hAA, 1); send_byte(8'h55, 1);
    send_byte(8'h0F, 0); send_byte(8'h17, 0);
    send_byte(8'h11, 1); send_byte(8'h22, 1);
    settle();
    check("p_nwr", wr_q.size(), 4);
    expect_wr("p_wr0", 0, 0, 10'd421, 8'hAA);
    expect_wr("p_wr1", 1, 0, 10'd422, 8'h55);
    expect_wr("p_wr127", 2, 0, 10'd511, 8'h11);
    expect_wr("p_wrap", 3, 0, 10'd384, 8'h22);

    // vertical mode, window col 10..11 page 2..3
    send_byte(8'h20, 0); send_byte(8'h01, 0);
    send_byte(8'h21, 0); send_byte(8'h0A, 0); send_byte(8'h0B, 0);
    send_byte(8'h22, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
    settle();
    clear_q();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    settle();
    check("v_nwr", wr_q.size(), 5);
    expect_wr("v_wr0", 0, 0, 10'd266, 8'h01);
    expect_wr("v_wr1", 1, 0, 10'd394, 8'h02);
    expect_wr("v_wr2", 2, 0, 10'd267, 8'h03);
    expect_wr("v_wr3", 3, 1, 10'd395, 8'h04);
    expect_wr("v_wr4", 4, 0, 10'd266, 8'h05);

    // partial byte discarded by csn
    clear_q();
    for (int k = 0; k < 5; k++) spi_bit(k[0], 1'b1);
    cs_end();
    cs_start();
    send_byte(8'h40, 1);
    settle();
    check("cs_nbytes", by_q.size(), 1);
    check("cs_byte", 32'((by_q.size() > 0) ? by_q[0] : 'x), 32'h140);
    check("cs_nwr", wr_q.size(), 1);
    expect_wr("cs_wr", 0, 0, 10'd394, 8'h40);

    // 0x21 swallowed as contrast parameter
    send_byte(8'h81, 0); send_byte(8'h21, 0);
    send_byte(8'h0B, 0); send_byte(8'h0A, 0);
    settle();
    clear_q();
    send_byte(8'hC1, 1); send_byte(8'hC2, 1); send_byte(8'hC3, 1);
    settle();
    check("sk_nwr", wr_q.size(), 3);
    expect_wr("sk_wr0", 0, 0, 10'd266, 8'hC1);
    expect_wr("sk_wr1", 1, 0, 10'd394, 8'hC2);
    expect_wr("sk_wr2", 2, 0, 10'd267, 8'hC3);

    // async reset mid-byte
    for (int k = 0; k < 4; k++) spi_bit(1'b1, 1'b1);
    @(posedge clk_in);
    #3 resetn_in = 1'b0;
    #1 check_outs_zero("mid");
    oled_csn_in = 1'b1;
    oled_clk_in = 1'b0;
    repeat (4) @(posedge clk_in);
    #1 resetn_in = 1'b1;
    repeat (3) @(posedge clk_in);
    clear_q();
    cs_start();
    send_byte(8'h77, 1);
    settle();
    check("post_nwr", wr_q.size(), 1);
    expect_wr("post_wr", 0, 0, 10'd0, 8'h77);
    check("post_disp", 32'(display_on_out), 0);
    check("stray_frame", stray_frame, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
